cache_set_ram: RTL and testbench

One direct-mapped cache way (32 lines × 128-bit data, 10-bit tag, valid and dirty bits) with its own backing line memory. It serves byte, halfword and word reads and writes, allocates on miss, and writes back dirty lines on eviction or flush. It is the per-way storage and memory engine that the two-way cache controller builds on.

---
 rtl/cache_set_ram_if.sv | 16 +
 rtl/cache_set_ram.sv | 204 ++++++++++++++++++++
 tb/tb_cache_set_ram.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_set_ram_if.sv
// Request/response bus between a cache controller (master) and one cache way (slave).
interface cache_set_ram_if #(
    parameter int ADDR_W = 15
);
    logic [2:0]        cmd;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        offset;
    logic [31:0]       wdata;
    logic              ready;
    logic              done;
    logic              hit;
    logic [31:0]       rdata;

    modport master (output cmd, addr, offset, wdata, input ready, done, hit, rdata);
    modport slave  (input cmd, addr, offset, wdata, output ready, done, hit, rdata);
endinterface

// File: rtl/cache_set_ram.sv
// One direct-mapped cache way with its backing line memory, write-back / write-allocate.
// Optional CACHE_SET_RAM_STATS_EN adds saturating hit_cnt / miss_cnt outputs.
module cache_set_ram #(
    parameter int TAG_W     = 10,
    parameter int INDEX_W   = 5,
    parameter int LINE_W    = 128,
    parameter int MEM_LINES = 2**(TAG_W+INDEX_W)
) (
    input  logic           clk,
    input  logic           rst,
    cache_set_ram_if.slave bus
`ifdef CACHE_SET_RAM_STATS_EN
    ,
    output logic [15:0]    hit_cnt,
    output logic [15:0]    miss_cnt
`endif
);
    localparam int SETS   = 2**INDEX_W;
    localparam int ADDR_W = TAG_W + INDEX_W;
    localparam int LBYTES = LINE_W / 8;

    localparam logic [2:0] CMD_NOP   = 3'd0;
    localparam logic [2:0] CMD_FLUSH = 3'd4;

    typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_t;

    function automatic int size_bytes(input logic [1:0] sz);
        case (sz)
            2'd1:    return 1;
            2'd2:    return 2;
            default: return 4;
        endcase
    endfunction

    // Bytes that fall past the end of the line read as zero; no wrap-around.
    function automatic logic [31:0] extract_bytes(input logic [LINE_W-1:0] ln,
                                                  input logic [3:0] off, input int nb);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            if (k < nb && int'(off) + k < LBYTES)
                r[8*k +: 8] = ln[8*(int'(off)+k) +: 8];
        end
        return r;
    endfunction

    function automatic logic [LINE_W-1:0] merge_bytes(input logic [LINE_W-1:0] ln,
                                                      input logic [3:0] off,
                                                      input logic [31:0] wd, input int nb);
        logic [LINE_W-1:0] r;
        r = ln;
        for (int k = 0; k < 4; k++) begin
            if (k < nb && int'(off) + k < LBYTES)
                r[8*(int'(off)+k) +: 8] = wd[8*k +: 8];
        end
        return r;
    endfunction

`ifdef CACHE_SET_RAM_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
`endif

    state_t                        state;
    logic [2:0]                    cmd_q;
    logic [ADDR_W-1:0]             addr_q;
    logic [3:0]                    off_q;
    logic [31:0]                   wdata_q;
    logic [SETS-1:0][TAG_W-1:0]    tag_array;
    logic [SETS-1:0]               valid;
    logic [SETS-1:0]               dirty;
    logic [LINE_W-1:0]             line [SETS];
    logic [LINE_W-1:0]             mem  [MEM_LINES];

    logic                          accept;
    logic [2:0]                    cur_cmd;
    logic [ADDR_W-1:0]             cur_addr;
    logic [3:0]                    cur_off;
    logic [31:0]                   cur_wdata;
    logic [INDEX_W-1:0]            cur_idx;
    logic [TAG_W-1:0]              cur_tag;
    logic                          is_hit, is_dirty, is_flush, is_write, is_read;
    logic [LINE_W-1:0]             base_line, wr_line;
    logic [31:0]                   rd_val;

    // In IDLE the live request is used so hits complete on the accepting edge.
    always_comb begin
        accept    = (state == IDLE) && (bus.cmd != CMD_NOP);
        cur_cmd   = cmd_q;
        cur_addr  = addr_q;
        cur_off   = off_q;
        cur_wdata = wdata_q;
        if (state == IDLE) begin
            cur_cmd   = bus.cmd;
            cur_addr  = bus.addr;
            cur_off   = bus.offset;
            cur_wdata = bus.wdata;
        end
        cur_idx   = cur_addr[INDEX_W-1:0];
        cur_tag   = cur_addr[ADDR_W-1:INDEX_W];
        is_flush  = (cur_cmd == CMD_FLUSH);
        is_write  = cur_cmd[2] && !is_flush;
        is_read   = !cur_cmd[2] && (cur_cmd != CMD_NOP);
        is_hit    = valid[cur_idx] && (tag_array[cur_idx] == cur_tag);
        is_dirty  = valid[cur_idx] && dirty[cur_idx];
        base_line = (state == FILL) ? mem[cur_addr] : line[cur_idx];
        rd_val    = extract_bytes(base_line, cur_off, size_bytes(cur_cmd[1:0]));
        wr_line   = merge_bytes(base_line, cur_off, cur_wdata, size_bytes(cur_cmd[1:0]));
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            cmd_q   <= bus.cmd;
            addr_q  <= bus.addr;
            off_q   <= bus.offset;
            wdata_q <= bus.wdata;
        end
        if (!rst) begin
            if (accept && is_hit && is_write)
                line[cur_idx] <= wr_line;
            if (state == FILL)
                line[cur_idx] <= is_write ? wr_line : base_line;
            if (state == WB)
                mem[{tag_array[cur_idx], cur_idx}] <= line[cur_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bus.ready <= 1'b1;
            bus.done  <= 1'b0;
            bus.hit   <= 1'b0;
            bus.rdata <= '0;
            valid     <= '0;
            dirty     <= '0;
            tag_array <= '0;
`ifdef CACHE_SET_RAM_STATS_EN
            hit_cnt   <= '0;
            miss_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (accept) begin
                    bus.ready <= 1'b0;
                    if (is_flush) begin
                        if (is_hit && dirty[cur_idx]) begin
                            state <= WB;
                        end else begin
                            state    <= RESP;
                            bus.done <= 1'b1;
                            bus.hit  <= is_hit;
                            if (is_hit) begin
                                valid[cur_idx] <= 1'b0;
                                dirty[cur_idx] <= 1'b0;
                            end
                        end
                    end else if (is_hit) begin
                        state    <= RESP;
                        bus.done <= 1'b1;
                        bus.hit  <= 1'b1;
                        if (is_read)  bus.rdata <= rd_val;
                        if (is_write) dirty[cur_idx] <= 1'b1;
`ifdef CACHE_SET_RAM_STATS_EN
                        hit_cnt <= sat_inc(hit_cnt);
`endif
                    end else begin
                        state <= is_dirty ? WB : FILL;
                    end
                end
                WB: begin
                    if (is_flush) begin
                        state          <= RESP;
                        bus.done       <= 1'b1;
                        bus.hit        <= 1'b1;
                        valid[cur_idx] <= 1'b0;
                        dirty[cur_idx] <= 1'b0;
                    end else begin
                        state <= FILL;
                    end
                end
                FILL: begin
                    state              <= RESP;
                    bus.done           <= 1'b1;
                    bus.hit            <= 1'b0;
                    tag_array[cur_idx] <= cur_tag;
                    valid[cur_idx]     <= 1'b1;
                    dirty[cur_idx]     <= is_write;
                    if (is_read) bus.rdata <= rd_val;
`ifdef CACHE_SET_RAM_STATS_EN
                    miss_cnt <= sat_inc(miss_cnt);
`endif
                end
                RESP: begin
                    state     <= IDLE;
                    bus.done  <= 1'b0;
                    bus.ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_set_ram.sv
// Scoreboard bench for cache_set_ram: directed cases with literal expectations, then
// random traffic checked against a byte-level reference model of the way and its memory.
module tb_cache_set_ram;
    localparam bit [2:0] READ8 = 3'd1, READ16 = 3'd2, READ32 = 3'd3, FLUSH = 3'd4;
    localparam bit [2:0] WRITE8 = 3'd5, WRITE16 = 3'd6, WRITE32 = 3'd7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_set_ram_if bus ();
`ifdef CACHE_SET_RAM_STATS_EN
    logic [15:0] hit_cnt, miss_cnt;
`endif

    cache_set_ram dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef CACHE_SET_RAM_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    typedef struct {
        bit        h;
        bit [31:0] rd;
        int        lat;
        int        acc;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    bit [127:0] m_line  [32];
    bit [9:0]   m_tag   [32];
    bit         m_valid [32];
    bit         m_dirty [32];
    bit [127:0] m_mem   [int];
    bit [31:0]  m_rdata = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got=0x%08h want=0x%08h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic bit [127:0] mem_rd(input int key);
        return m_mem.exists(key) ? m_mem[key] : 128'b0;
    endfunction

    function automatic void model_req(input bit [2:0] c, input bit [14:0] a, input bit [3:0] o,
                                      input bit [31:0] wd, output bit h, output int lat);
        int idx, n, p;
        bit [9:0] tg;
        bit [127:0] ln;
        idx = int'(a[4:0]);
        tg  = a[14:5];
        n   = (c[1:0] == 2'd1) ? 1 : (c[1:0] == 2'd2) ? 2 : 4;
        h   = m_valid[idx] && (m_tag[idx] == tg);
        lat = 1;
        if (c == FLUSH) begin
            if (h) begin
                if (m_dirty[idx]) begin
                    lat = 2;
                    m_mem[int'({m_tag[idx], a[4:0]})] = m_line[idx];
                end
                m_valid[idx] = 1'b0;
                m_dirty[idx] = 1'b0;
            end
        end else begin
            if (!h) begin
                lat = 2;
                if (m_valid[idx] && m_dirty[idx]) begin
                    lat = 3;
                    m_mem[int'({m_tag[idx], a[4:0]})] = m_line[idx];
                end
                m_line[idx]  = mem_rd(int'(a));
                m_tag[idx]   = tg;
                m_valid[idx] = 1'b1;
                m_dirty[idx] = 1'b0;
            end
            ln = m_line[idx];
            if (c[2]) begin
                for (int k = 0; k < n; k++) begin
                    p = int'(o) + k;
                    if (p < 16) ln[8*p +: 8] = wd[8*k +: 8];
                end
                m_line[idx]  = ln;
                m_dirty[idx] = 1'b1;
            end else begin
                m_rdata = '0;
                for (int k = 0; k < n; k++) begin
                    p = int'(o) + k;
                    if (p < 16) m_rdata[8*k +: 8] = ln[8*p +: 8];
                end
            end
        end
    endfunction

    function automatic void model_wb_only(input bit [14:0] a);
        int idx;
        idx = int'(a[4:0]);
        if (m_valid[idx] && m_dirty[idx] && m_tag[idx] != a[14:5])
            m_mem[int'({m_tag[idx], a[4:0]})] = m_line[idx];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = '0;
        end
        m_rdata = '0;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                check("spurious_done", bus.done, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("hit", 32'(bus.hit), 32'(e.h));
                check("rdata", bus.rdata, e.rd);
                check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            end
        end
    end

    task automatic issue(input bit [2:0] c, input bit [14:0] a, input bit [3:0] o,
                         input bit [31:0] wd, input bit want_done, input bit use_lit,
                         input bit lh, input bit [31:0] lrd, input int llat);
        int   n;
        bit   mh;
        int   mlat;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!bus.ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready) begin
            check("ready_timeout", 32'(bus.ready), 32'd1);
            return;
        end
        if (want_done) begin
            model_req(c, a, o, wd, mh, mlat);
            e.h   = use_lit ? lh : mh;
            e.rd  = use_lit ? lrd : m_rdata;
            e.lat = use_lit ? llat : mlat;
            e.acc = cyc + 1;
            sb.push_back(e);
        end else begin
            model_wb_only(a);
        end
        bus.cmd    = c;
        bus.addr   = a;
        bus.offset = o;
        bus.wdata  = wd;
        @(negedge clk);
        bus.cmd = 3'd0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("done_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic req(input bit [2:0] c, input bit [14:0] a, input bit [3:0] o,
                       input bit [31:0] wd, input bit h, input bit [31:0] rd, input int lat);
        issue(c, a, o, wd, 1'b1, 1'b1, h, rd, lat);
        wait_done();
    endtask

    task automatic rnd_req(input bit [2:0] c, input bit [14:0] a, input bit [3:0] o,
                           input bit [31:0] wd);
        issue(c, a, o, wd, 1'b1, 1'b0, 1'b0, 32'd0, 0);
        wait_done();
    endtask

    initial begin
        bit [4:0] ridx;
        rst        = 1'b1;
        bus.cmd    = 3'd0;
        bus.addr   = '0;
        bus.offset = '0;
        bus.wdata  = '0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_done",  32'(bus.done),  32'd0);
        check("rst_hit",   32'(bus.hit),   32'd0);
        check("rst_rdata", bus.rdata,      32'd0);
        @(negedge clk);
        rst = 1'b0;

        req(READ32,  15'h0000, 4'd0,  32'h0,        1'b0, 32'h00000000, 2);
        req(READ32,  15'h0000, 4'd0,  32'h0,        1'b1, 32'h00000000, 1);
        req(WRITE16, 15'h0023, 4'd2,  32'h0000BEEF, 1'b0, 32'h00000000, 2);
        req(READ8,   15'h0023, 4'd3,  32'h0,        1'b1, 32'h000000BE, 1);
        req(READ16,  15'h0023, 4'd2,  32'h0,        1'b1, 32'h0000BEEF, 1);
        req(WRITE32, 15'h0003, 4'd4,  32'h12345678, 1'b0, 32'h0000BEEF, 3);
        req(READ32,  15'h0023, 4'd0,  32'h0,        1'b0, 32'hBEEF0000, 3);
        req(READ32,  15'h0003, 4'd4,  32'h0,        1'b0, 32'h12345678, 2);
        req(WRITE32, 15'h0003, 4'd14, 32'hAABBCCDD, 1'b1, 32'h12345678, 1);
        req(READ32,  15'h0003, 4'd14, 32'h0,        1'b1, 32'h0000CCDD, 1);
        req(FLUSH,   15'h0003, 4'd0,  32'h0,        1'b1, 32'h0000CCDD, 2);
        req(READ32,  15'h0003, 4'd4,  32'h0,        1'b0, 32'h12345678, 2);
        req(READ32,  15'h0003, 4'd14, 32'h0,        1'b1, 32'h0000CCDD, 1);
        req(FLUSH,   15'h0045, 4'd0,  32'h0,        1'b0, 32'h0000CCDD, 1);
        req(FLUSH,   15'h0000, 4'd0,  32'h0,        1'b1, 32'h0000CCDD, 1);

        // Dirty miss interrupted by reset while the fill is in progress.
        req(WRITE8,  15'h0007, 4'd0,  32'h0000005A, 1'b0, 32'h0000CCDD, 2);
        issue(READ32, 15'h0027, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_ready", 32'(bus.ready), 32'd1);
        check("mid_rst_done",  32'(bus.done),  32'd0);
        check("mid_rst_rdata", bus.rdata,      32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        req(READ8,   15'h0007, 4'd0,  32'h0,        1'b0, 32'h0000005A, 2);
        req(READ32,  15'h0023, 4'd0,  32'h0,        1'b0, 32'hBEEF0000, 2);

        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 2))
                0:       ridx = 5'd3;
                1:       ridx = 5'd7;
                default: ridx = 5'd9;
            endcase
            rnd_req(3'($urandom_range(1, 7)), {10'($urandom_range(0, 2)), ridx},
                    4'($urandom_range(0, 15)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
